// File: rtl/gpp_rx_buffer.sv
// gpp_rx_buffer: receive FIFO between the communications processor link and
// the general-purpose processor datapath. Show-ahead head word, sticky
// overflow flag, non-stallable link side.
//
// Optional feature macro: GPP_RX_DROP_COUNT_EN adds a saturating 16-bit
// count of dropped words (drop_count), cleared by overflow_clear.
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous active-low reset
//   link_valid      one-cycle strobe, link_data valid
//   link_data       incoming word from the link
//   rx_read         pop strobe from the datapath
//   overflow_clear  synchronous clear of rx_overflow (and drop_count)
//   RAM_rx_data_out head word when non-empty, else 0 (combinational read)
//   data_rx_flag    FIFO non-empty
//   rx_count        occupancy 0..DEPTH
//   rx_full         occupancy == DEPTH
//   rx_almost_full  occupancy >= ALMOST_FULL_LEVEL
//   rx_overflow     sticky: a word was dropped
//   drop_count      dropped-word counter (only with GPP_RX_DROP_COUNT_EN)
module gpp_rx_buffer #(
    parameter int unsigned WIDTH             = 16,
    parameter int unsigned DEPTH             = 8,
    parameter int unsigned ALMOST_FULL_LEVEL = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         link_valid,
    input  logic [WIDTH-1:0]             link_data,
    input  logic                         rx_read,
    input  logic                         overflow_clear,
    output logic [WIDTH-1:0]             RAM_rx_data_out,
    output logic                         data_rx_flag,
    output logic [$clog2(DEPTH):0]       rx_count,
    output logic                         rx_full,
    output logic                         rx_almost_full,
`ifdef GPP_RX_DROP_COUNT_EN
    output logic [15:0]                  drop_count,
`endif
    output logic                         rx_overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic empty;
    logic full;
    logic do_pop;
    logic do_push;
    logic drop;

    // Status decode from the registered count only.
    assign empty = (count == CNT_W'(0));
    assign full  = (count == CNT_W'(DEPTH));

    // A same-cycle pop frees a slot, so a push into a full FIFO is accepted.
    assign do_pop  = rx_read && !empty;
    assign do_push = link_valid && (!full || do_pop);
    assign drop    = link_valid && full && !do_pop;

    // Storage: written only on accepted pushes, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= link_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_overflow <= 1'b0;
        end else if (drop) begin
            rx_overflow <= 1'b1;
        end else if (overflow_clear) begin
            rx_overflow <= 1'b0;
        end
    end

`ifdef GPP_RX_DROP_COUNT_EN
    // Saturating drop counter; a drop coinciding with a clear restarts at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_count <= '0;
        end else if (drop) begin
            if (overflow_clear) begin
                drop_count <= 16'd1;
            end else if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end else if (overflow_clear) begin
            drop_count <= '0;
        end
    end
`endif

    assign RAM_rx_data_out = empty ? '0 : mem[rd_ptr];
    assign data_rx_flag    = !empty;
    assign rx_count        = count;
    assign rx_full         = full;
    assign rx_almost_full  = (count >= CNT_W'(ALMOST_FULL_LEVEL));

endmodule

// File: tb/tb_gpp_rx_buffer.sv
// Testbench for gpp_rx_buffer: directed scenarios plus randomized traffic,
// checked against a queue-based reference model.
module tb_gpp_rx_buffer;

    localparam int DEPTH = 8;
    localparam int AFL   = 6;

    logic        clk;
    logic        rst;
    logic        link_valid;
    logic [15:0] link_data;
    logic        rx_read;
    logic        overflow_clear;
    logic [15:0] RAM_rx_data_out;
    logic        data_rx_flag;
    logic [3:0]  rx_count;
    logic        rx_full;
    logic        rx_almost_full;
    logic        rx_overflow;
`ifdef GPP_RX_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    gpp_rx_buffer #(.WIDTH(16), .DEPTH(DEPTH), .ALMOST_FULL_LEVEL(AFL)) dut (
        .clk            (clk),
        .rst            (rst),
        .link_valid     (link_valid),
        .link_data      (link_data),
        .rx_read        (rx_read),
        .overflow_clear (overflow_clear),
        .RAM_rx_data_out(RAM_rx_data_out),
        .data_rx_flag   (data_rx_flag),
        .rx_count       (rx_count),
        .rx_full        (rx_full),
        .rx_almost_full (rx_almost_full),
`ifdef GPP_RX_DROP_COUNT_EN
        .drop_count     (drop_count),
`endif
        .rx_overflow    (rx_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: queue of stored words, sticky overflow, drop tally.
    logic [15:0] mq [$];
    logic        m_ovf = 1'b0;
    int          m_drop = 0;

    function automatic logic [15:0] m_head();
        if (mq.size() > 0) return mq[0];
        return 16'h0000;
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
    endfunction

    // One clock: drive inputs, take the edge, update the model, settle, idle inputs.
    task automatic cycle(input logic lv, input logic [15:0] ld, input logic rd, input logic oc);
        logic        popped;
        logic        accepted;
        logic [15:0] tmp;
        link_valid     = lv;
        link_data      = ld;
        rx_read        = rd;
        overflow_clear = oc;
        @(posedge clk);
        popped   = rd && (mq.size() > 0);
        accepted = lv && ((mq.size() - int'(popped)) < DEPTH);
        if (popped) tmp = mq.pop_front();
        if (accepted) mq.push_back(ld);
        if (lv && !accepted) begin
            m_ovf = 1'b1;
            if (oc) m_drop = 1;
            else if (m_drop < 65535) m_drop++;
        end else if (oc) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        #1;
        link_valid     = 1'b0;
        rx_read        = 1'b0;
        overflow_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        link_valid = 1'b0; link_data = '0; rx_read = 1'b0; overflow_clear = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (data_rx_flag !== 1'b0) $display("FAIL reset_flag got=%b exp=0", data_rx_flag); else passes++;
        checks++; if (RAM_rx_data_out !== 16'h0000) $display("FAIL reset_data got=%h exp=0000", RAM_rx_data_out); else passes++;
        checks++; if (rx_count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", rx_count); else passes++;
        checks++; if ({rx_full, rx_almost_full, rx_overflow} !== 3'b000)
            $display("FAIL reset_status got=%b exp=000", {rx_full, rx_almost_full, rx_overflow}); else passes++;
    endtask

    task automatic test_basic();
        logic [15:0] exp_words [3];
        exp_words[0] = 16'hA001; exp_words[1] = 16'hA002; exp_words[2] = 16'hA003;
        cycle(1'b1, 16'hA001, 1'b0, 1'b0);
        checks++; if (RAM_rx_data_out !== 16'hA001 || data_rx_flag !== 1'b1)
            $display("FAIL basic_first_head got=%h/%b exp=a001/1", RAM_rx_data_out, data_rx_flag); else passes++;
        cycle(1'b1, 16'hA002, 1'b0, 1'b0);
        cycle(1'b1, 16'hA003, 1'b0, 1'b0);
        checks++; if (rx_count !== 4'd3) $display("FAIL basic_count got=%0d exp=3", rx_count); else passes++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (RAM_rx_data_out !== exp_words[i])
                $display("FAIL basic_pop%0d got=%h exp=%h", i, RAM_rx_data_out, exp_words[i]); else passes++;
            cycle(1'b0, 16'h0, 1'b1, 1'b0);
        end
        checks++; if (data_rx_flag !== 1'b0 || RAM_rx_data_out !== 16'h0000)
            $display("FAIL basic_empty got=%b/%h exp=0/0000", data_rx_flag, RAM_rx_data_out); else passes++;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 16'(16'h0010 + i), 1'b0, 1'b0);
            checks++; if (rx_almost_full !== ((i + 1) >= AFL))
                $display("FAIL fill_afull n=%0d got=%b exp=%b", i + 1, rx_almost_full, ((i + 1) >= AFL)); else passes++;
            checks++; if (rx_full !== ((i + 1) == DEPTH))
                $display("FAIL fill_full n=%0d got=%b exp=%b", i + 1, rx_full, ((i + 1) == DEPTH)); else passes++;
        end
        checks++; if (rx_overflow !== 1'b0) $display("FAIL fill_no_ovf got=%b exp=0", rx_overflow); else passes++;
        cycle(1'b1, 16'hDEAD, 1'b0, 1'b0);
        checks++; if (rx_overflow !== 1'b1) $display("FAIL ovf_set got=%b exp=1", rx_overflow); else passes++;
        checks++; if (rx_count !== 4'd8) $display("FAIL ovf_count got=%0d exp=8", rx_count); else passes++;
        checks++; if (RAM_rx_data_out !== 16'h0010) $display("FAIL ovf_head got=%h exp=0010", RAM_rx_data_out); else passes++;
`ifdef GPP_RX_DROP_COUNT_EN
        checks++; if (drop_count !== 16'd1) $display("FAIL ovf_drop_count got=%0d exp=1", drop_count); else passes++;
`endif
    endtask

    task automatic test_full_push_pop();
        logic [15:0] exp_w;
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        checks++; if (rx_overflow !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", rx_overflow); else passes++;
        cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
        checks++; if (RAM_rx_data_out !== 16'h0011) $display("FAIL fpp_head got=%h exp=0011", RAM_rx_data_out); else passes++;
        checks++; if (rx_count !== 4'd8) $display("FAIL fpp_count got=%0d exp=8", rx_count); else passes++;
        checks++; if (rx_overflow !== 1'b0) $display("FAIL fpp_ovf got=%b exp=0", rx_overflow); else passes++;
        for (int i = 0; i < DEPTH; i++) begin
            exp_w = (i == DEPTH - 1) ? 16'hBEEF : 16'(16'h0011 + i);
            checks++; if (RAM_rx_data_out !== exp_w)
                $display("FAIL fpp_drain%0d got=%h exp=%h", i, RAM_rx_data_out, exp_w); else passes++;
            cycle(1'b0, 16'h0, 1'b1, 1'b0);
        end
        checks++; if (rx_count !== 4'd0) $display("FAIL fpp_empty got=%0d exp=0", rx_count); else passes++;
    endtask

    task automatic test_wrap();
        int next_rd = 0;
        for (int i = 0; i < 20; i++) begin
            if (i >= 2) begin
                checks++; if (RAM_rx_data_out !== 16'(16'h0100 + next_rd))
                    $display("FAIL wrap_word%0d got=%h exp=%h", next_rd, RAM_rx_data_out, 16'(16'h0100 + next_rd)); else passes++;
                next_rd++;
            end
            cycle(1'b1, 16'(16'h0100 + i), (i >= 2), 1'b0);
            checks++; if (rx_count > 4'd3) $display("FAIL wrap_occ got=%0d exp<=3", rx_count); else passes++;
        end
        while (next_rd < 20) begin
            checks++; if (RAM_rx_data_out !== 16'(16'h0100 + next_rd))
                $display("FAIL wrap_word%0d got=%h exp=%h", next_rd, RAM_rx_data_out, 16'(16'h0100 + next_rd)); else passes++;
            next_rd++;
            cycle(1'b0, 16'h0, 1'b1, 1'b0);
        end
        checks++; if (data_rx_flag !== 1'b0) $display("FAIL wrap_empty got=%b exp=0", data_rx_flag); else passes++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
        checks++; if (rx_count !== 4'd5) $display("FAIL ar_pre_count got=%0d exp=5", rx_count); else passes++;
        #2 rst = 1'b0;
        #1;
        m_reset();
        checks++; if (rx_count !== 4'd0 || data_rx_flag !== 1'b0 || RAM_rx_data_out !== 16'h0000)
            $display("FAIL ar_immediate got=%0d/%b/%h exp=0/0/0000", rx_count, data_rx_flag, RAM_rx_data_out); else passes++;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        checks++; if (rx_count !== 4'd0 || rx_overflow !== 1'b0)
            $display("FAIL ar_empty_read got=%0d/%b exp=0/0", rx_count, rx_overflow); else passes++;
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'(16'h0300 + i), 1'b0, 1'b0);
        cycle(1'b1, 16'hFACE, 1'b0, 1'b1);
        checks++; if (rx_overflow !== 1'b1) $display("FAIL ar_clear_vs_set got=%b exp=1", rx_overflow); else passes++;
`ifdef GPP_RX_DROP_COUNT_EN
        checks++; if (drop_count !== 16'd1) $display("FAIL ar_drop_clear got=%0d exp=1", drop_count); else passes++;
`endif
        checks++; if (RAM_rx_data_out !== 16'h0300) $display("FAIL ar_head got=%h exp=0300", RAM_rx_data_out); else passes++;
    endtask

    task automatic test_random();
        logic        lv, rd, oc;
        logic [15:0] d;
        for (int c = 0; c < 400; c++) begin
            lv = ($urandom_range(0, 99) < 55);
            rd = ($urandom_range(0, 99) < 45);
            oc = ($urandom_range(0, 99) < 5);
            d  = 16'($urandom);
            cycle(lv, d, rd, oc);
            checks++; if (RAM_rx_data_out !== m_head())
                $display("FAIL rand_head c=%0d got=%h exp=%h", c, RAM_rx_data_out, m_head()); else passes++;
            checks++; if (rx_count !== 4'(mq.size()))
                $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, rx_count, mq.size()); else passes++;
            checks++; if ({data_rx_flag, rx_full, rx_almost_full} !== {mq.size() > 0, mq.size() == DEPTH, mq.size() >= AFL})
                $display("FAIL rand_status c=%0d got=%b exp=%b", c, {data_rx_flag, rx_full, rx_almost_full},
                         {mq.size() > 0, mq.size() == DEPTH, mq.size() >= AFL}); else passes++;
            checks++; if (rx_overflow !== m_ovf)
                $display("FAIL rand_ovf c=%0d got=%b exp=%b", c, rx_overflow, m_ovf); else passes++;
`ifdef GPP_RX_DROP_COUNT_EN
            checks++; if (drop_count !== 16'(m_drop))
                $display("FAIL rand_drop c=%0d got=%0d exp=%0d", c, drop_count, m_drop); else passes++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_overflow();
        test_full_push_pop();
        test_wrap();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
